// File: rtl/rf_writeback_arb.sv
// rf_writeback_arb: ALU/LSU result FIFOs, round-robin register-file write port, RAW pending mask.
// Define WB_PERF_CNT_EN to add per-source grant counters alu_wb_cnt/lsu_wb_cnt.
module rf_wb_fifo #(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [AW-1:0]   din_rd,
    input  logic [DW-1:0]   din_data,
    output logic            full,
    output logic            empty,
    output logic [AW-1:0]   head_rd,
    output logic [DW-1:0]   head_data,
    output logic [2**AW-1:0] pend
);
    localparam int PW = $clog2(DEPTH);
    logic [PW:0]   wp, rp, cnt;
    logic [AW-1:0] rd_q   [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    assign cnt       = wp - rp;
    assign full      = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
    assign empty     = wp == rp;
    assign head_rd   = rd_q[rp[PW-1:0]];
    assign head_data = data_q[rp[PW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wp[PW-1:0]]   <= din_rd;
            data_q[wp[PW-1:0]] <= din_data;
        end
    end
    // walk the occupied slots starting at the read pointer
    always_comb begin
        pend = '0;
        for (int k = 0; k < DEPTH; k++)
            if ((PW+1)'(k) < cnt) pend[rd_q[rp[PW-1:0] + PW'(k)]] = 1'b1;
    end
endmodule

module rf_writeback_arb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_WIDTH-1:0]    alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [ADDR_WIDTH-1:0]    lsu_rd,
    input  logic [DATA_WIDTH-1:0]    lsu_data,
    output logic                     rf_wen,
    output logic [ADDR_WIDTH-1:0]    rf_waddr,
    output logic [DATA_WIDTH-1:0]    rf_wdata,
    output logic [2**ADDR_WIDTH-1:0] pending
`ifdef WB_PERF_CNT_EN
    ,
    output logic [31:0]              alu_wb_cnt,
    output logic [31:0]              lsu_wb_cnt
`endif
);
    localparam int NREG = 2**ADDR_WIDTH;
    logic a_full, a_empty, l_full, l_empty, gnt_a, gnt_l, last_a;
    logic [ADDR_WIDTH-1:0] a_rd, l_rd, sel_rd;
    logic [DATA_WIDTH-1:0] a_data, l_data;
    logic [NREG-1:0]       a_pend, l_pend;
    assign alu_ready = rst_n && !a_full;
    assign lsu_ready = rst_n && !l_full;
    // last_a=1 means ALU won most recently, so LSU wins the next tie
    assign gnt_a  = !a_empty && (l_empty || !last_a);
    assign gnt_l  = !l_empty && !gnt_a;
    assign sel_rd = gnt_a ? a_rd : l_rd;
    rf_wb_fifo #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk(clk), .rst_n(rst_n), .push(alu_valid && alu_ready), .pop(gnt_a),
        .din_rd(alu_rd), .din_data(alu_data), .full(a_full), .empty(a_empty),
        .head_rd(a_rd), .head_data(a_data), .pend(a_pend)
    );
    rf_wb_fifo #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_lsu_fifo (
        .clk(clk), .rst_n(rst_n), .push(lsu_valid && lsu_ready), .pop(gnt_l),
        .din_rd(lsu_rd), .din_data(lsu_data), .full(l_full), .empty(l_empty),
        .head_rd(l_rd), .head_data(l_data), .pend(l_pend)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            last_a   <= 1'b1;
        end else begin
            rf_wen <= (gnt_a || gnt_l) && sel_rd != '0;
            if (gnt_a || gnt_l) begin
                rf_waddr <= sel_rd;
                rf_wdata <= gnt_a ? a_data : l_data;
                last_a   <= gnt_a;
            end
        end
    end
    always_comb begin
        pending = a_pend | l_pend;
        if (rf_wen) pending[rf_waddr] = 1'b1;
        pending[0] = 1'b0;
    end
`ifdef WB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_wb_cnt <= '0;
            lsu_wb_cnt <= '0;
        end else begin
            if (gnt_a) alu_wb_cnt <= alu_wb_cnt + 32'd1;
            if (gnt_l) lsu_wb_cnt <= lsu_wb_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_rf_writeback_arb.sv
// tb_rf_writeback_arb: queue-model scoreboard plus directed scenarios for rf_writeback_arb.
module tb_rf_writeback_arb;
    typedef struct packed {logic [4:0] rd; logic [31:0] d;} pkt_t;
    logic clk, rst_n;
    logic alu_valid, alu_ready, lsu_valid, lsu_ready, rf_wen;
    logic [4:0] alu_rd, lsu_rd, rf_waddr;
    logic [31:0] alu_data, lsu_data, rf_wdata, pending;
`ifdef WB_PERF_CNT_EN
    logic [31:0] alu_wb_cnt, lsu_wb_cnt;
`endif
    int vec = 0, errs = 0, cyc = 0;
    pkt_t aq[$], lq[$], wlog[$];
    int wcyc[$];
    logic m_wen, m_last_a;
    logic [4:0] m_waddr;
    logic [31:0] m_wdata;
    int m_acnt, m_lcnt;
    bit saw_full;

    rf_writeback_arb dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending(pending)
`ifdef WB_PERF_CNT_EN
        , .alu_wb_cnt(alu_wb_cnt), .lsu_wb_cnt(lsu_wb_cnt)
`endif
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        vec++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s got=%0h want=%0h", n, a, e);
        end
    endtask

    function automatic logic [31:0] m_pending();
        logic [31:0] p = '0;
        foreach (aq[i]) p[aq[i].rd] = 1'b1;
        foreach (lq[i]) p[lq[i].rd] = 1'b1;
        if (m_wen) p[m_waddr] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    // Outputs are stable at negedge; compare, then advance the model by the coming posedge.
    always @(negedge clk) begin
        pkt_t p;
        bit a_room, l_room, take_a, take_l;
        if (!rst_n) begin
            aq.delete(); lq.delete();
            m_wen = 0; m_waddr = 0; m_wdata = 0; m_last_a = 1; m_acnt = 0; m_lcnt = 0;
        end
        chk("wen", rf_wen, m_wen);
        chk("waddr", rf_waddr, m_waddr);
        chk("wdata", rf_wdata, m_wdata);
        chk("pending", pending, m_pending());
        chk("alu_ready", alu_ready, rst_n && aq.size() < 2);
        chk("lsu_ready", lsu_ready, rst_n && lq.size() < 2);
`ifdef WB_PERF_CNT_EN
        chk("alu_cnt", alu_wb_cnt, m_acnt);
        chk("lsu_cnt", lsu_wb_cnt, m_lcnt);
`endif
        if (rf_wen) begin
            wlog.push_back({rf_waddr, rf_wdata});
            wcyc.push_back(cyc);
        end
        if (rst_n && !alu_ready) saw_full = 1;
        if (rst_n) begin
            a_room = aq.size() < 2;
            l_room = lq.size() < 2;
            if (aq.size() > 0 && lq.size() > 0) take_a = !m_last_a;
            else take_a = aq.size() > 0;
            take_l = !take_a && lq.size() > 0;
            if (take_a || take_l) begin
                if (take_a) begin p = aq.pop_front(); m_acnt++; end
                else begin p = lq.pop_front(); m_lcnt++; end
                m_wen = p.rd != 0; m_waddr = p.rd; m_wdata = p.d; m_last_a = take_a;
            end else m_wen = 0;
            if (alu_valid && a_room) aq.push_back({alu_rd, alu_data});
            if (lsu_valid && l_room) lq.push_back({lsu_rd, lsu_data});
        end
    end

    task automatic send_alu(input logic [4:0] rd, input logic [31:0] d);
        bit taken = 0;
        alu_valid = 1; alu_rd = rd; alu_data = d;
        for (int i = 0; i < 100 && !taken; i++) begin
            @(negedge clk) taken = alu_ready;
            @(posedge clk) #2;
        end
        if (!taken) begin vec++; errs++; $display("FAIL alu_send_timeout rd=%0d got=0 want=1", rd); end
        alu_valid = 0;
    endtask

    task automatic send_lsu(input logic [4:0] rd, input logic [31:0] d);
        bit taken = 0;
        lsu_valid = 1; lsu_rd = rd; lsu_data = d;
        for (int i = 0; i < 100 && !taken; i++) begin
            @(negedge clk) taken = lsu_ready;
            @(posedge clk) #2;
        end
        if (!taken) begin vec++; errs++; $display("FAIL lsu_send_timeout rd=%0d got=0 want=1", rd); end
        lsu_valid = 0;
    endtask

    initial begin
        int n0, ia, il;
        logic [4:0] r;
        rst_n = 0; alu_valid = 0; lsu_valid = 0;
        alu_rd = 0; lsu_rd = 0; alu_data = 0; lsu_data = 0;
        @(negedge clk) #1;
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_wen", rf_wen, 0);
        chk("rst_pending", pending, 0);
        @(posedge clk) #3 rst_n = 1;
        @(negedge clk) #1 chk("post_rst_ready", {alu_ready, lsu_ready}, 2'b11);

        // single ALU write: latency and pending[5] lifetime
        @(posedge clk) #2;
        send_alu(5, 32'hDEADBEEF);
        @(negedge clk) #1;
        chk("t1_pend_acc", pending[5], 1);
        chk("t1_wen_early", rf_wen, 0);
        @(negedge clk) #1;
        chk("t1_write", {rf_wen, rf_waddr, rf_wdata}, {1'b1, 5'd5, 32'hDEADBEEF});
        chk("t1_pend_stage", pending[5], 1);
        @(negedge clk) #1;
        chk("t1_pend_clear", pending[5], 0);
        chk("t1_wen_done", rf_wen, 0);

        // both sources streaming: LSU first, then strict alternation
        n0 = wlog.size();
        @(posedge clk) #2;
        fork
            for (int i = 0; i < 4; i++) send_alu(5'(1 + i), 32'hA000_0000 + 1 + i);
            for (int i = 0; i < 4; i++) send_lsu(5'(9 + i), 32'hB000_0000 + 9 + i);
        join
        repeat (6) @(negedge clk);
        #1;
        chk("t2_count", wlog.size() - n0, 8);
        for (int k = 0; k < 8; k++) begin
            r = (k % 2 == 0) ? 5'(9 + k / 2) : 5'(1 + k / 2);
            chk("t2_order", wlog[n0 + k], {r, ((k % 2 == 0) ? 32'hB000_0000 : 32'hA000_0000) | 32'(r)});
        end
        chk("t2_span", wcyc[n0 + 7] - wcyc[n0], 7);

        // ALU backpressure with LSU competing; pointers wrap past 2*DEPTH
        n0 = wlog.size(); saw_full = 0;
        @(posedge clk) #2;
        fork
            for (int i = 0; i < 6; i++) send_alu(5'(16 + i), 32'hC000_0000 + 16 + i);
            for (int i = 0; i < 6; i++) send_lsu(5'(22 + i), 32'hD000_0000 + 22 + i);
        join
        repeat (8) @(negedge clk);
        #1;
        ia = 0; il = 0;
        for (int i = n0; i < wlog.size(); i++) begin
            if (wlog[i].rd < 22) begin
                chk("t4_alu_seq", wlog[i], {5'(16 + ia), 32'hC000_0000 + 16 + ia});
                ia++;
            end else begin
                chk("t4_lsu_seq", wlog[i], {5'(22 + il), 32'hD000_0000 + 22 + il});
                il++;
            end
        end
        chk("t4_counts", {ia[7:0], il[7:0]}, {8'd6, 8'd6});
        chk("t4_alu_backpressure", saw_full, 1);

        // rd==0 load is consumed without a write
        n0 = wlog.size();
        @(posedge clk) #2;
        send_lsu(0, 32'h1234);
        @(negedge clk) #1 chk("t3_pend_r0", pending, 0);
        @(negedge clk) #1 chk("t3_wdata_loaded", {rf_wen, rf_waddr, rf_wdata}, {1'b0, 5'd0, 32'h1234});
        repeat (3) @(negedge clk);
        #1 chk("t3_no_write", wlog.size() - n0, 0);

        // async reset with packets buffered and one staged
        @(posedge clk) #2;
        fork
            send_alu(7, 32'h7777);
            send_lsu(8, 32'h8888);
        join
        fork
            send_alu(13, 32'h1313);
            send_lsu(14, 32'h1414);
        join
        n0 = wlog.size();
        #1 rst_n = 0;
        #1;
        chk("t5_async_wen", rf_wen, 0);
        chk("t5_async_pending", pending, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        repeat (6) @(negedge clk);
        #1;
        chk("t5_no_stale_write", wlog.size() - n0, 0);
        chk("t5_pending_idle", pending, 0);

        // grant counters: 3 ALU + 2 LSU, one LSU dropped at rd 0
        @(posedge clk) #2;
        send_alu(1, 32'h1); send_alu(2, 32'h2); send_alu(3, 32'h3);
        send_lsu(0, 32'h0); send_lsu(6, 32'h6);
        repeat (4) @(negedge clk);
        #1;
`ifdef WB_PERF_CNT_EN
        chk("perf_alu", alu_wb_cnt, 3);
        chk("perf_lsu", lsu_wb_cnt, 2);
`endif
        chk("perf_writes", wlog.size() - n0, 4);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
